// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable instruction memory, pc and registered issue.
// Optional fetch counter enabled by defining IFU_FETCH_COUNT_EN.
module instr_fetch_unit #(
  parameter int          ADDR_W      = 8,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
`ifdef IFU_FETCH_COUNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [15:0]       instr_n;
  logic              valid_n;
  logic              accept;
  logic              issue;
  logic [15:0]       word;
  logic [15:0]       imem [DEPTH];

  assign word   = imem[pc];
  assign busy   = (state == FETCH);
  assign halted = (state == HALT);

  // Loads are only honoured while the fetch path is not reading memory.
  always_ff @(posedge clk) begin
    if (load_en && state != FETCH)
      imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instruction;
    valid_n = instr_valid;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          state_n = FETCH;
          pc_n    = '0;
          instr_n = '0;
          valid_n = 1'b0;
          accept  = 1'b1;
        end
      end
      FETCH: begin
        if (!stall) begin
          if (word[15:12] == HALT_OPCODE) begin
            // Halt word is consumed but never issued; pc stays on it.
            state_n = HALT;
            instr_n = '0;
            valid_n = 1'b0;
          end else begin
            instr_n = word;
            valid_n = 1'b1;
            pc_n    = pc + ADDR_W'(1);
            issue   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IFU_FETCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_count <= '0;
    else if (accept)
      fetch_count <= '0;
    else if (issue && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'd1;
  end
`else
  logic unused_issue;
  assign unused_issue = issue ^ accept;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: abstract model checked every cycle
// plus directed literal expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        busy;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .halted(halted),
`ifdef IFU_FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: running/halted flags, a word array and a fetch pointer.
  logic [15:0] m_mem [256];
  bit          m_run, m_halt;
  logic [7:0]  m_pc;
  logic [15:0] m_ins;
  bit          m_val;
  logic [15:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_halt <= 0; m_pc <= 0;
      m_ins <= 0; m_val <= 0; m_cnt <= 0;
    end else if (!m_run) begin
      if (load_en) m_mem[load_addr] <= load_data;
      if (start) begin
        m_run <= 1; m_halt <= 0; m_pc <= 0;
        m_ins <= 0; m_val <= 0; m_cnt <= 0;
      end
    end else if (!stall) begin
      if (m_mem[m_pc][15:12] == 4'hF) begin
        m_run <= 0; m_halt <= 1; m_ins <= 0; m_val <= 0;
      end else begin
        m_ins <= m_mem[m_pc];
        m_val <= 1;
        m_pc  <= m_pc + 8'd1;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_instruction", 32'(instruction), 32'(m_ins));
      chk("cmp_valid", 32'(instr_valid), 32'(m_val));
      chk("cmp_pc", 32'(pc), 32'(m_pc));
      chk("cmp_halted", 32'(halted), 32'(m_halt));
      chk("cmp_busy", 32'(busy), 32'(m_run));
`ifdef IFU_FETCH_COUNT_EN
      chk("cmp_count", 32'(fetch_count), 32'(m_cnt));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d;
    cyc();
    load_en = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic prog3();
    load(8'd0, 16'h1298);
    load(8'd1, 16'h2298);
    load(8'd2, 16'hF000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    rst = 1;
    repeat (2) cyc();
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 0;
    chk_on = 1;

    // Scenario 1: basic run to halt
    prog3();
    start = 1; cyc(); start = 0;
    cyc();
    chk("s1_e1_instr", 32'(instruction), 32'h1298);
    chk("s1_e1_valid", 32'(instr_valid), 32'h1);
    chk("s1_e1_pc", 32'(pc), 32'h1);
    cyc();
    chk("s1_e2_instr", 32'(instruction), 32'h2298);
    chk("s1_e2_pc", 32'(pc), 32'h2);
    cyc();
    chk("s1_e3_instr", 32'(instruction), 32'h0);
    chk("s1_e3_valid", 32'(instr_valid), 32'h0);
    chk("s1_e3_halted", 32'(halted), 32'h1);
    chk("s1_e3_busy", 32'(busy), 32'h0);
    chk("s1_e3_pc", 32'(pc), 32'h2);
`ifdef IFU_FETCH_COUNT_EN
    chk("s1_count", 32'(fetch_count), 32'h2);
`endif
    stall = 1; cyc(); cyc(); stall = 0;
    chk("halt_stall_noeffect", 32'(halted), 32'h1);

    // Scenario 2: stall after E1
    start = 1; cyc(); start = 0;
`ifdef IFU_FETCH_COUNT_EN
    chk("s2_start_clr", 32'(fetch_count), 32'h0);
`endif
    cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s2_stall_instr", 32'(instruction), 32'h1298);
      chk("s2_stall_pc", 32'(pc), 32'h1);
    end
    stall = 0;
    cyc();
    chk("s2_after_instr", 32'(instruction), 32'h2298);
    chk("s2_after_pc", 32'(pc), 32'h2);
    cyc();
    chk("s2_halted", 32'(halted), 32'h1);
`ifdef IFU_FETCH_COUNT_EN
    chk("s2_count", 32'(fetch_count), 32'h2);
`endif

    // Scenario 3: full memory, pc wrap
    for (int a = 0; a < 256; a++) load(8'(a), 16'h1000 | 16'(a));
    start = 1; cyc(); start = 0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 100) start = 1;
      cyc();
      start = 0;
    end
    chk("s3_last_instr", 32'(instruction), 32'h10FF);
    chk("s3_wrap_pc", 32'(pc), 32'h0);
    load(8'd0, 16'h5111);
    chk("s3_after_wrap", 32'(instruction), 32'h1000);

    // Scenario 5: async reset mid-fetch
    rst = 1;
    #1;
    chk("s5_instr", 32'(instruction), 32'h0);
    chk("s5_valid", 32'(instr_valid), 32'h0);
    chk("s5_pc", 32'(pc), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    cyc();
    rst = 0;
    cyc();
    start = 1; cyc(); start = 0;
    cyc();
    chk("s5_refetch", 32'(instruction), 32'h1000);
    chk("s5_refetch_pc", 32'(pc), 32'h1);
    do_reset();

    // Scenario 4: load ignored in FETCH, honoured in HALT
    prog3();
    start = 1; cyc(); start = 0;
    load(8'd0, 16'h5111);
    repeat (3) cyc();
    chk("s4_halted", 32'(halted), 32'h1);
    start = 1; cyc(); start = 0;
    cyc();
    chk("s4_fetch_load_ignored", 32'(instruction), 32'h1298);
    repeat (3) cyc();
    load_en = 1; load_addr = 8'd0; load_data = 16'h5111; start = 1;
    cyc();
    load_en = 0; start = 0;
    cyc();
    chk("s4_halt_load_used", 32'(instruction), 32'h5111);
    repeat (3) cyc();
    chk("s4_end_halted", 32'(halted), 32'h1);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the 16-bit single-cycle processor core. Holds a loadable instruction memory and a program counter, and presents one 16-bit instruction per cycle on a registered output. Stalls on request and halts on a halt opcode. Bubbles are driven as 16'h0000 (opcode 0), which the downstream control unit decodes as no register write and no memory access.

Parameters:
ADDR_W, 8, PC and instruction-memory address width; memory depth = 2**ADDR_W words of 16 bits.
HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching; the halt word itself is never issued.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; begins fetching from address 0 (accepted in IDLE or HALT only).
stall  input  1  freezes pc, instruction and instr_valid while high (FETCH only).
load_en  input  1  instruction-memory write strobe.
load_addr  input  ADDR_W  write address.
load_data  input  16  write data.
instruction  output  16  registered instruction to the processor core; 16'h0000 when not valid.
instr_valid  output  1  instruction holds a real fetched word.
pc  output  ADDR_W  address of the next word to fetch.
halted  output  1  high while in HALT.
busy  output  1  high while in FETCH.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, instruction=16'h0000, instr_valid=0, halted=0, busy=0. Memory contents are not reset.
- States: IDLE, FETCH, HALT. busy is high only in FETCH; halted is high only in HALT.
- IDLE/HALT + start: next state FETCH, pc<=0, instruction<=0, instr_valid<=0, halted<=0.
- start in FETCH: ignored.
- FETCH, stall=0, imem[pc][15:12]!=HALT_OPCODE: instruction<=imem[pc], instr_valid<=1, pc<=pc+1.
  - The word at address A appears on instruction one edge after pc==A is sampled.
- FETCH, stall=0, imem[pc][15:12]==HALT_OPCODE:
  - instruction<=0, instr_valid<=0, state<=HALT.
  - pc holds the halt word's address.
- FETCH, stall=1: pc, instruction, instr_valid and state all hold. Halt detection is not evaluated.
- stall in IDLE/HALT: no effect.
- pc wrap: pc+1 is computed modulo 2**ADDR_W, so DEPTH-1 wraps to 0 and fetching continues.
- Memory writes: load_en is honoured only in IDLE or HALT; it is ignored in FETCH.
  - Load and start in the same cycle: the write completes at that edge.
  - The first fetch occurs on the following edge, so the write is visible to it.
- Reset mid-fetch: outputs clear immediately with no further issue; start is required to resume.

Optional Feature:
Macro IFU_FETCH_COUNT_EN.
- Defined: adds output port fetch_count [15:0].
  - Increments on every edge where a word is issued (instr_valid<=1 with new data); stalled cycles do not count.
  - Saturates at 16'hFFFF.
  - Cleared by rst and by an accepted start.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, load mem[0]=16'h1298, mem[1]=16'h2298, mem[2]=16'hF000, pulse start at edge E0.
   - E1: instruction=16'h1298, instr_valid=1, pc=1.
   - E2: instruction=16'h2298, pc=2.
   - E3: instruction=16'h0000, instr_valid=0, halted=1, busy=0, pc=2.
2. Same program, stall=1 for 3 cycles after E1.
   - During stall: instruction holds 16'h1298, pc holds 1.
   - First edge after stall drops: instruction=16'h2298, pc=2.
3. ADDR_W=8, memory filled with 16'h1000|addr and no halt word.
   - After 16'h10FF issues: pc=0, next instruction=16'h1000.
4. While in FETCH, load_en=1 with load_addr=0, load_data=16'h5111.
   - After halt and restart, first instruction is still 16'h1298.
   - Same write performed in HALT, then start: first instruction=16'h5111.
5. Assert rst mid-cycle during FETCH.
   - instruction=0, instr_valid=0, pc=0, busy=0 before the next edge.
   - After release, a start pulse refetches from address 0.
6. With IFU_FETCH_COUNT_EN defined, run scenario 1.
   - After halt: fetch_count=2.
   - Scenario 2 stall cycles do not increment the count.
   - An accepted start resets fetch_count to 0.
